// File: rtl/fsm_step_seq.sv
// Parametrised step sequencer: walks NUM_STATES indices up/down on a matching code,
// wrapping or saturating at the ends, with illegal-encoding recovery and a sticky err flag.
module fsm_step_seq #(
  parameter int                NUM_STATES = 4,
  parameter int                IN_W       = 3,
  parameter int                OUT_W      = 3,
  parameter logic [IN_W-1:0]   ADV_CODE   = '0,
  parameter bit                WRAP_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  user_input,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  output logic [OUT_W-1:0] out,
  output logic             at_last,
  output logic             wrap,
  output logic             sat,
  output logic             err
);

  localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);
  localparam logic [SW:0]   LIMIT = (SW + 1)'(NUM_STATES);

  generate
    if (OUT_W < SW) begin : g_out_w_check
      $error("fsm_step_seq: OUT_W is narrower than the state register");
    end
    if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_num_states_check
      $error("fsm_step_seq: NUM_STATES must be in 2..256");
    end
  endgenerate

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_RECOVER,
    ACT_INC,
    ACT_DEC,
    ACT_WRAP_UP,
    ACT_WRAP_DN,
    ACT_SAT
  } act_t;

  logic [SW-1:0] state, state_nxt;
  logic          wrap_nxt, sat_nxt, err_nxt;
  logic          step, illegal;
  act_t          act;

  assign step    = en && (user_input == ADV_CODE);
  // Only reachable when NUM_STATES is not a power of two; compare one bit wider.
  assign illegal = ({1'b0, state} >= LIMIT);

  always_comb begin
    act = ACT_HOLD;
    if (clear) begin
      act = ACT_CLEAR;
    end else if (illegal) begin
      act = ACT_RECOVER;
    end else if (step) begin
      if (!dir) begin
        if (state != LAST)   act = ACT_INC;
        else if (WRAP_EN)    act = ACT_WRAP_UP;
        else                 act = ACT_SAT;
      end else begin
        if (state != '0)     act = ACT_DEC;
        else if (WRAP_EN)    act = ACT_WRAP_DN;
        else                 act = ACT_SAT;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wrap_nxt  = 1'b0;
    sat_nxt   = 1'b0;
    err_nxt   = err;
    case (act)
      ACT_HOLD:    state_nxt = state;
      ACT_CLEAR:   state_nxt = '0;
      ACT_RECOVER: begin
        state_nxt = '0;
        err_nxt   = 1'b1;
      end
      ACT_INC:     state_nxt = state + SW'(1);
      ACT_DEC:     state_nxt = state - SW'(1);
      ACT_WRAP_UP: begin
        state_nxt = '0;
        wrap_nxt  = 1'b1;
      end
      ACT_WRAP_DN: begin
        state_nxt = LAST;
        wrap_nxt  = 1'b1;
      end
      ACT_SAT:     sat_nxt = 1'b1;
      default:     state_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= wrap_nxt;
      sat   <= sat_nxt;
      err   <= err_nxt;
    end
  end

  assign out     = OUT_W'(state);
  assign at_last = (state == LAST);

endmodule

// File: doc/fsm_step_seq.md
Name: fsm_step_seq

Overview:
- Parametrised successor to the fixed 4-state step FSM.
- A NUM_STATES-state sequencer advances one step each cycle that the enabled input matches a programmable code. It supports up/down direction, wrap or saturate at the ends, and hardened recovery from illegal state encodings with a sticky error flag.
- Sits between user-input decode and downstream output select logic. Its output is the current state index.

Parameters:
NUM_STATES, 4, number of legal states (2..256); legal encodings 0..NUM_STATES-1
IN_W, 3, width of user_input
OUT_W, 3, width of out; must be >= SW = max(1, clog2(NUM_STATES)); elaboration error otherwise
ADV_CODE, 0, user_input value that requests a step (IN_W bits)
WRAP_EN, 1, 1 = wrap at ends; 0 = saturate at ends

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
user_input  input  IN_W  step request when equal to ADV_CODE
en  input  1  qualifies step requests; 0 = hold
dir  input  1  0 = count up, 1 = count down
clear  input  1  synchronous return to state 0
out  output  OUT_W  current state index, zero-extended; combinational from the state register
at_last  output  1  state == NUM_STATES-1 (combinational)
wrap  output  1  registered one-cycle pulse on a wrap transition
sat  output  1  registered; high while a step request is blocked at an end (WRAP_EN=0 only)
err  output  1  sticky; set on detection of an illegal state encoding

Behaviour:
- Reset is synchronous: rst_n=0 at a clk edge gives state=0, wrap=0, sat=0, err=0. Hence out=0 and at_last=0 (at_last=1 only if NUM_STATES=1, which is illegal).
- State register width is SW. Encodings >= NUM_STATES are illegal; they can only occur when NUM_STATES is not a power of two.
- step = en && (user_input == ADV_CODE), evaluated at the clk edge.
- Per-edge priority: rst_n low > clear > illegal recovery > step > hold.
- clear=1:
  - state becomes 0; wrap and sat become 0.
  - err is not cleared; only reset clears err.
- Illegal state, i.e. state >= NUM_STATES, regardless of step/dir:
  - next state = 0, err becomes 1.
  - wrap and sat become 0.
  - No step is taken on that edge.
- Step up (dir=0):
  - state < NUM_STATES-1: state+1.
  - state == NUM_STATES-1 with WRAP_EN=1: state becomes 0 and wrap=1 for exactly the next cycle.
  - state == NUM_STATES-1 with WRAP_EN=0: state holds and sat=1.
- Step down (dir=1):
  - state > 0: state-1.
  - state == 0 with WRAP_EN=1: state becomes NUM_STATES-1 and wrap=1.
  - state == 0 with WRAP_EN=0: state holds and sat=1.
- No step: state holds; wrap=0 and sat=0. wrap and sat reflect only the most recent edge.
- Latency: a step sampled at edge k is visible on out and at_last immediately after edge k, with no extra pipeline stage.
- The next-state case statement has a default branch that goes to 0. Neither state nor out may produce X or latch for any encoding.
- dir changes take effect on the same edge they are sampled. There are no hidden modes.
- rst_n asserted mid-sequence overrides all other inputs on that edge.

Test Plan:
- Reset, then en=1, user_input=0, dir=0 for 5 cycles (defaults) -> out = 1,2,3,0,1; wrap=1 only in the cycle out=0; at_last=1 only when out=3.
- NUM_STATES=5, dir=1 from state 0, step each cycle -> out = 4,3,2,1,0,4; wrap pulses on 0->4 each time; user_input=1 or en=0 -> out holds.
- WRAP_EN=0, NUM_STATES=4: step up 5 times -> out = 1,2,3,3,3; sat=1 on the 4th and 5th edges and wrap never asserts; then dir=1 step -> out=2, sat=0.
- NUM_STATES=5: force state=6 for one edge with step=1 -> out=0, err=1 (sticky). clear=1 -> err stays 1. rst_n=0 for one edge -> err=0.
- clear=1 and step=1 on the same edge from state 2 -> out=0, wrap=0. rst_n=0 with clear=1 mid-sequence -> all outputs at reset values next cycle.
